// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters.
// Operands are registered onto the ALU for EXEC_CYCLES cycles, then Z is captured and returned.
module alu_share_arbiter #(
    parameter int EXEC_CYCLES = 1,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid_0,
    input  logic        req_valid_1,
    output logic        req_ready_0,
    output logic        req_ready_1,
    input  logic [31:0] req_a_0,
    input  logic [31:0] req_a_1,
    input  logic [31:0] req_b_0,
    input  logic [31:0] req_b_1,
    input  logic [5:0]  req_fun_0,
    input  logic [5:0]  req_fun_1,
    input  logic        req_sign_0,
    input  logic        req_sign_1,
    output logic        rsp_valid_0,
    output logic        rsp_valid_1,
    input  logic        rsp_ready_0,
    input  logic        rsp_ready_1,
    output logic [31:0] rsp_data,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [5:0]  alu_fun,
    output logic        alu_sign,
    input  logic [31:0] alu_z,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_prio;
    logic              r_owner;
    logic [CNT_W-1:0]  r_count;
    logic [31:0]       r_alu_a;
    logic [31:0]       r_alu_b;
    logic [5:0]        r_alu_fun;
    logic              r_alu_sign;
    logic [31:0]       r_rsp_data;

    logic              w_idle;
    logic              w_grant;
    logic              w_winner;
    logic              w_rsp_take;
    logic [CNT_W-1:0]  w_last_count;

    assign w_idle       = (r_state == S_IDLE);
    assign w_grant      = w_idle && (req_valid_0 || req_valid_1);
    // On a tie the priority bit decides; otherwise the lone valid requester wins.
    assign w_winner     = (req_valid_0 && req_valid_1) ? r_prio : req_valid_1;
    assign w_rsp_take   = r_owner ? rsp_ready_1 : rsp_ready_0;
    assign w_last_count = CNT_W'(EXEC_CYCLES - 1);

    assign req_ready_0  = w_grant && !w_winner;
    assign req_ready_1  = w_grant && w_winner;
    assign rsp_valid_0  = (r_state == S_RESP) && !r_owner;
    assign rsp_valid_1  = (r_state == S_RESP) && r_owner;
    assign busy         = !w_idle;
    assign rsp_data     = r_rsp_data;
    assign alu_a        = r_alu_a;
    assign alu_b        = r_alu_b;
    assign alu_fun      = r_alu_fun;
    assign alu_sign     = r_alu_sign;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_prio     <= 1'b0;
            r_owner    <= 1'b0;
            r_count    <= '0;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_fun  <= '0;
            r_alu_sign <= 1'b0;
            r_rsp_data <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_alu_a    <= w_winner ? req_a_1    : req_a_0;
                        r_alu_b    <= w_winner ? req_b_1    : req_b_0;
                        r_alu_fun  <= w_winner ? req_fun_1  : req_fun_0;
                        r_alu_sign <= w_winner ? req_sign_1 : req_sign_0;
                        r_owner    <= w_winner;
                        r_count    <= '0;
                        r_state    <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_count <= r_count + 1'b1;
                    if (r_count == w_last_count) begin
                        r_rsp_data <= alu_z;
                        r_state    <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (w_rsp_take) begin
                        r_prio  <= ~r_owner;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational ALU (32-bit A/B, 6-bit ALUFun, sign, 32-bit Z) between two requesters, e.g. the main execute path and a multi-cycle helper unit.
- Accepts one operation at a time through a valid/ready handshake and arbitrates round-robin when both requesters are active.
- Drives the ALU from registered operands for a fixed number of cycles, captures Z and returns it to the winning requester through a valid/ready response handshake.

Parameters:
- EXEC_CYCLES, 1, cycles operands are held on the ALU before Z is captured (1..15); allows for a slow ALU path.
- CNT_W, 4, width of the execute counter; must hold EXEC_CYCLES.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous reset, active high.
- req_valid_0 / req_valid_1  input  1  requester n has an operation.
- req_ready_0 / req_ready_1  output  1  operation of requester n accepted this cycle.
- req_a_0 / req_a_1  input  32  operand A.
- req_b_0 / req_b_1  input  32  operand B.
- req_fun_0 / req_fun_1  input  6  ALUFun code.
- req_sign_0 / req_sign_1  input  1  signed compare/overflow select.
- rsp_valid_0 / rsp_valid_1  output  1  result for requester n is valid.
- rsp_ready_0 / rsp_ready_1  input  1  requester n takes the result.
- rsp_data  output  32  captured ALU result, shared by both response channels.
- alu_a  output  32  to ALU A.
- alu_b  output  32  to ALU B.
- alu_fun  output  6  to ALU ALUFun.
- alu_sign  output  1  to ALU sign.
- alu_z  input  32  from ALU Z.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async, immediate):
  - state=IDLE, prio=0 (requester 0 wins the first tie), owner=0, count=0.
  - All ready and rsp_valid outputs 0; rsp_data=0; alu_a/alu_b/alu_fun/alu_sign=0; busy=0.
- FSM states are IDLE, EXEC and RESP.
- IDLE:
  - Only one requester valid: grant it.
  - Both valid: grant prio.
  - On grant, req_ready of the winner is high combinationally that cycle; all other ready outputs stay 0.
  - On that edge: latch winner's a/b/fun/sign into the alu_* registers, owner=winner, count=0, go to EXEC.
  - Neither valid: stay in IDLE and hold the alu_* registers.
- EXEC:
  - alu_* outputs stay constant. count increments each cycle.
  - When count==EXEC_CYCLES-1: rsp_data<=alu_z and go to RESP.
  - Latency from accept edge to rsp_valid is EXEC_CYCLES+1 edges.
- RESP:
  - rsp_valid_owner=1, rsp_valid of the other requester = 0, rsp_data held.
  - On rsp_ready_owner=1: go to IDLE and set prio=~owner.
  - Requester arrivals during RESP are not accepted; they wait for IDLE.
- Throughput: at most one operation per EXEC_CYCLES+2 cycles; no pipelining, one operation outstanding.
- Fairness: after a requester is served, the other wins the next tie. A lone requester may be served back to back.
- No ready in EXEC/RESP: req_ready_0 and req_ready_1 are 0 outside IDLE.
- Requester rules:
  - A requester must hold its payload stable while valid and not ready.
  - Dropping valid before ready is permitted; the request is then simply not taken.
- rsp_ready held high: the response lasts exactly one cycle.
- rsp_ready asserted outside RESP, or by the non-owner: ignored.
- Reset mid-operation (EXEC or RESP): the operation is discarded, no response is issued, and all outputs take reset values immediately.
- Arithmetic: none in this block. Z is captured verbatim (32 bits), and codes the ALU does not decode pass through unchanged.
- Counter: count wraps only through the state change. EXEC_CYCLES=1 gives a single EXEC cycle.

Test Plan:
- Single add:
  - Stimulus: EXEC_CYCLES=1, req0 valid with a=5, b=7, fun=000000.
  - Required: ready_0 high in cycle 0; rsp_valid_0 high from cycle 2 with rsp_data=12; after rsp_ready_0, busy low and prio=1.
- Simultaneous requests after reset:
  - Stimulus: req0 sub with a=3, b=5, fun=000001; req1 and with a=0xF0F0F0F0, b=0x0FF0FF00, fun=011000.
  - Required: req0 served first with 0xFFFFFFFE, then req1 with 0x00F0F000.
  - Stimulus: both then request again.
  - Required: req0 wins, since prio returned to 0 after req1 was served.
- Response backpressure:
  - Stimulus: rsp_ready_1 held low for 5 cycles on a signed slt with a=0xFFFFFFFF, b=1, fun=110101, sign=1.
  - Required: rsp_valid_1 and rsp_data=1 stable through the stall; req_ready_0 stays low despite req_valid_0 being high.
- Multi-cycle hold:
  - Stimulus: EXEC_CYCLES=3, sll with a=4, b=1, fun=100000.
  - Required: alu_* constant for 3 EXEC cycles; rsp_data=16 at accept+4.
- Reset mid-operation:
  - Stimulus: assert reset asynchronously (between edges) during EXEC, then deassert; then issue req1.
  - Required: all outputs 0 immediately; no rsp_valid afterwards; req1 is served normally.
- Lone requester streaming:
  - Stimulus: req0 valid continuously for 4 operations, rsp_ready_0 tied high.
  - Required: ready_0 pulses every 3 cycles; no response goes to requester 1.
